// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NUM_PORTS  = 2;
    localparam int unsigned RAM_ADDR_W = 14;
    localparam int unsigned RAM_DATA_W = 256;

    typedef logic port_id_t;

    localparam port_id_t PORT_VLSU = 1'b0;
    localparam port_id_t PORT_HOST = 1'b1;

    typedef struct packed {
        logic                    we;
        logic [RAM_ADDR_W-1:0]   addr;
        logic [RAM_DATA_W/8-1:0] be;
        logic [RAM_DATA_W-1:0]   wdata;
    } ram_req_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid/owner shift register that tags each issued RAM read and releases the
// tag when the read data comes back, RD_LAT cycles later.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     issue,
    input  port_id_t owner,
    output logic     rvalid0,
    output logic     rvalid1
);

    logic [RD_LAT-1:0] vldSr;
    logic [RD_LAT-1:0] ownSr;

    always_ff @(posedge clk) begin
        if (reset) begin
            vldSr <= '0;
            ownSr <= '0;
        end else begin
            vldSr[0] <= issue;
            ownSr[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vldSr[i] <= vldSr[i-1];
                ownSr[i] <= ownSr[i-1];
            end
        end
    end

    assign rvalid0 = vldSr[RD_LAT-1] && (ownSr[RD_LAT-1] == PORT_VLSU);
    assign rvalid1 = vldSr[RD_LAT-1] && (ownSr[RD_LAT-1] == PORT_HOST);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the data-RAM port between the VLSU (port 0, priority) and the host
// loader (port 1, starvation-guarded). Define ARB_PERF_EN for perf counters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_ADDR_W,
    parameter int unsigned DATA_W     = RAM_DATA_W,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                we0,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [DATA_W/8-1:0] be0,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W/8-1:0] be1,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy0,
    output logic                ram_rden,
    output logic                ram_wren,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [95:0]         perf_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starveCnt;
    logic             force1;
    logic             grant;
    port_id_t         winner;
    ram_req_t         portReq [NUM_PORTS];
    ram_req_t         sel;
    logic             pipeRv0;
    logic             pipeRv1;

    always_comb begin
        portReq[PORT_VLSU] = '{we: we0, addr: addr0, be: be0, wdata: wdata0};
        portReq[PORT_HOST] = '{we: we1, addr: addr1, be: be1, wdata: wdata1};

        // Grants are held low throughout reset so nothing reaches the RAM.
        force1 = (starveCnt == STARVE_LIM) && req1;
        gnt1   = !reset && req1 && (!req0 || force1);
        gnt0   = !reset && req0 && !gnt1;
        busy0  = !reset && req0 && !gnt0;
        grant  = gnt0 || gnt1;
        winner = gnt1 ? PORT_HOST : PORT_VLSU;
        sel    = grant ? portReq[winner] : '0;

        ram_rden  = grant && !sel.we;
        ram_wren  = grant && sel.we;
        ram_addr  = sel.addr;
        ram_be    = sel.be;
        ram_wdata = sel.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || gnt1 || !req1) begin
            starveCnt <= '0;
        end else if (starveCnt != STARVE_LIM) begin
            starveCnt <= starveCnt + CNT_W'(1);
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .issue   (ram_rden),
        .owner   (winner),
        .rvalid0 (pipeRv0),
        .rvalid1 (pipeRv1)
    );

    assign rvalid0 = pipeRv0 && !reset;
    assign rvalid1 = pipeRv1 && !reset;
    assign rdata   = ram_rdata;

`ifdef ARB_PERF_EN
    logic [31:0] grant0Cnt;
    logic [31:0] grant1Cnt;
    logic [31:0] conflictCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0Cnt   <= '0;
            grant1Cnt   <= '0;
            conflictCnt <= '0;
        end else begin
            if (gnt0 && (grant0Cnt != '1)) grant0Cnt <= grant0Cnt + 32'd1;
            if (gnt1 && (grant1Cnt != '1)) grant1Cnt <= grant1Cnt + 32'd1;
            if (req0 && req1 && (conflictCnt != '1)) conflictCnt <= conflictCnt + 32'd1;
        end
    end

    assign perf_cnt = {conflictCnt, grant1Cnt, grant0Cnt};
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table-driven arbitration vectors, directed read/write
// sequences and a randomized phase checked against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int unsigned AW         = 14;
    localparam int unsigned DW         = 256;
    localparam int unsigned BW         = DW / 8;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned DEPTH      = 1 << AW;

    logic          clk;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] be0, be1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy0, ram_rden, ram_wren;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be;
`ifdef ARB_PERF_EN
    logic [95:0]   perf_cnt;
`endif

    ram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .be0       (be0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .be1       (be1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .busy0     (busy0),
        .ram_rden  (ram_rden),
        .ram_wren  (ram_wren),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_cnt  (perf_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] initVal(int a);
        return {8{(32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000}};
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                            logic [BW-1:0] be);
        logic [DW-1:0] r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // RAM macro stand-in with RD_LAT-cycle read latency
    logic          ramClear;
    logic [DW-1:0] ramMem [DEPTH];
    logic [DW-1:0] rdPipe [RD_LAT];

    always @(posedge clk) begin
        if (ramClear) begin
            for (int i = 0; i < DEPTH; i++) ramMem[i] <= initVal(i);
        end else if (ram_wren) begin
            ramMem[ram_addr] <= merge(ramMem[ram_addr], ram_wdata, ram_be);
        end
        rdPipe[0] <= ram_rden ? ramMem[ram_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign ram_rdata = rdPipe[RD_LAT-1];

    // Reference model: expected memory contents and outstanding reads by due cycle
    typedef struct {
        int            due;
        logic          port;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] refMem [DEPTH];
    rd_t           pend [$];
    int            denied;
    int            cyc;
    int            nVec;
    int            nErr;
    logic          expG0, expG1, lastRv0, lastRv1;
    logic [DW-1:0] lastRdata;

    task automatic chk1(string name, logic act, logic exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s cyc=%0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chkV(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelCheck();
        logic          eg0, eg1, ew, ev0, ev1;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ed, erd;
        rd_t           r;
        if (reset) begin
            chk1("rst_gnt0", gnt0, 1'b0);
            chk1("rst_gnt1", gnt1, 1'b0);
            chk1("rst_rvalid0", rvalid0, 1'b0);
            chk1("rst_rvalid1", rvalid1, 1'b0);
            chk1("rst_busy0", busy0, 1'b0);
            chk1("rst_rden", ram_rden, 1'b0);
            chk1("rst_wren", ram_wren, 1'b0);
            chkV("rst_addr", 256'(ram_addr), '0);
            denied = 0;
            pend.delete();
            expG0 = 1'b0;
            expG1 = 1'b0;
        end else begin
            eg1 = req1 && (!req0 || (denied >= STARVE_MAX));
            eg0 = req0 && !eg1;
            expG0 = eg0;
            expG1 = eg1;
            chk1("gnt0", gnt0, eg0);
            chk1("gnt1", gnt1, eg1);
            chk1("busy0", busy0, req0 && !eg0);
            ew = 1'b0; ea = '0; eb = '0; ed = '0;
            if (eg0) begin
                ew = we0; ea = addr0; eb = be0; ed = wdata0;
            end else if (eg1) begin
                ew = we1; ea = addr1; eb = be1; ed = wdata1;
            end
            chk1("ram_rden", ram_rden, (eg0 || eg1) && !ew);
            chk1("ram_wren", ram_wren, (eg0 || eg1) && ew);
            chkV("ram_addr", 256'(ram_addr), 256'(ea));
            chkV("ram_be", 256'(ram_be), 256'(eb));
            chkV("ram_wdata", ram_wdata, ed);
            ev0 = 1'b0; ev1 = 1'b0; erd = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                ev0 = (r.port == 1'b0);
                ev1 = (r.port == 1'b1);
                erd = r.data;
            end
            chk1("rvalid0", rvalid0, ev0);
            chk1("rvalid1", rvalid1, ev1);
            if (ev0 || ev1) chkV("rdata", rdata, erd);
            denied = (req1 && !eg1) ? denied + 1 : 0;
            if (eg0 || eg1) begin
                if (ew) refMem[ea] = merge(refMem[ea], ed, eb);
                else pend.push_back('{due: cyc + RD_LAT, port: eg1, data: refMem[ea]});
            end
        end
        lastRv0 = rvalid0;
        lastRv1 = rvalid1;
        lastRdata = rdata;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        modelCheck();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;
    endtask

    typedef struct {
        logic r0;
        logic r1;
        logic eg0;
        logic eg1;
        logic eb0;
    } vec_t;

    vec_t tbl [23];
    logic hold0, hold1;

    initial begin
        nVec = 0; nErr = 0; cyc = 0; denied = 0;
        expG0 = 1'b0; expG1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = initVal(i);
        idle();
        reset = 1'b1;
        ramClear = 1'b1;
        tick();
        ramClear = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) tick();

        // Both ports held: 8 port-0 grants, then one forced port-1 grant, twice over
        for (int i = 0; i < 23; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 23; i++) begin
            req0 = tbl[i].r0; we0 = 1'b0; addr0 = AW'(i); be0 = '1;
            req1 = tbl[i].r1; we1 = 1'b0; addr1 = AW'(16'h0100 + i); be1 = '1;
            @(negedge clk);
            chk1("tbl_gnt0", gnt0, tbl[i].eg0);
            chk1("tbl_gnt1", gnt1, tbl[i].eg1);
            chk1("tbl_busy0", busy0, tbl[i].eb0);
            modelCheck();
            @(posedge clk);
            #1;
        end
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Lone port-0 read
        req0 = 1'b1; addr0 = AW'(16'h0010); be0 = '1;
        tick();
        idle();
        tick();
        tick();
        chk1("single_rvalid0", lastRv0, 1'b1);
        chk1("single_rvalid1", lastRv1, 1'b0);
        chkV("single_rdata", lastRdata, initVal(16'h0010));

        // Interleaved reads port 0, 1, 0 return in issue order
        req0 = 1'b1; addr0 = AW'(1); be0 = '1;
        tick();
        idle();
        req1 = 1'b1; addr1 = AW'(2); be1 = '1;
        tick();
        idle();
        req0 = 1'b1; addr0 = AW'(3); be0 = '1;
        tick();
        chk1("alt_rv0_a", lastRv0, 1'b1);
        chkV("alt_data_a", lastRdata, initVal(1));
        idle();
        tick();
        chk1("alt_rv1_b", lastRv1, 1'b1);
        chkV("alt_data_b", lastRdata, initVal(2));
        tick();
        chk1("alt_rv0_c", lastRv0, 1'b1);
        chkV("alt_data_c", lastRdata, initVal(3));
        tick();

        // Host write then VLSU read-back
        req1 = 1'b1; we1 = 1'b1; addr1 = AW'(16'h0100); be1 = '1; wdata1 = {32{8'hA5}};
        tick();
        idle();
        req0 = 1'b1; addr0 = AW'(16'h0100); be0 = '1;
        tick();
        idle();
        tick();
        tick();
        chk1("wr_rd_rvalid0", lastRv0, 1'b1);
        chkV("wr_rd_data", lastRdata, {32{8'hA5}});

        // Reset lands while a read is in flight
        req0 = 1'b1; addr0 = AW'(16'h0020); be0 = '1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
`ifdef ARB_PERF_EN
        chkV("perf_after_reset", 256'(perf_cnt), '0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("rst_mid_rvalid0", lastRv0, 1'b0);
        end

        // Randomized traffic obeying the hold-until-granted handshake
        hold0 = 1'b0;
        hold1 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                idle();
            end else begin
                reset = 1'b0;
                if (!hold0) begin
                    req0 = ($urandom_range(0, 3) != 0);
                    we0 = ($urandom_range(0, 2) == 0);
                    addr0 = AW'($urandom_range(0, 15));
                    be0 = $urandom;
                    wdata0 = {8{$urandom}};
                end
                if (!hold1) begin
                    req1 = ($urandom_range(0, 1) != 0);
                    we1 = ($urandom_range(0, 2) == 0);
                    addr1 = AW'($urandom_range(0, 15));
                    be1 = $urandom;
                    wdata1 = {8{$urandom}};
                end
            end
            tick();
            hold0 = req0 && !expG0;
            hold1 = req1 && !expG1;
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < RD_LAT + 2; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
